// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid/ready handshake, flush, and saturating stall counter.
// Ports: clk, rst (async, active-high); flush_i kills all slots;
//   id_valid_i/id_ready_o plus id_op_a_i, id_op_b_i, cu_alu_ctrl_i, id_reg_waddr_i, id_reg_we_i form the input side;
//   ex_valid_o/ex_ready_i plus ex_op_a_o, ex_op_b_o, ex_alu_ctrl_o, ex_reg_waddr_o, ex_reg_we_o form the output side;
//   stall_cnt_o counts ex_valid_o & ~ex_ready_i cycles and saturates at all-ones.
// Define ID_EX_SKID_EN to add a skid slot and make id_ready_o a register output.
module id_ex_pipe_reg #(
  parameter int                    DATA_W     = 32,
  parameter int                    REG_ADDR_W = 5,
  parameter int                    ALU_CTRL_W = 5,
  parameter logic [ALU_CTRL_W-1:0] NO_OP_CODE = '0,
  parameter int                    CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_W-1:0]     id_op_a_i,
  input  logic [DATA_W-1:0]     id_op_b_i,
  input  logic [ALU_CTRL_W-1:0] cu_alu_ctrl_i,
  input  logic [REG_ADDR_W-1:0] id_reg_waddr_i,
  input  logic                  id_reg_we_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_W-1:0]     ex_op_a_o,
  output logic [DATA_W-1:0]     ex_op_b_o,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o,
  output logic [REG_ADDR_W-1:0] ex_reg_waddr_o,
  output logic                  ex_reg_we_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);
  localparam int P_W = 2*DATA_W + ALU_CTRL_W + REG_ADDR_W + 1;
  localparam logic [P_W-1:0] BUBBLE = {{(2*DATA_W){1'b0}}, NO_OP_CODE, {(REG_ADDR_W+1){1'b0}}};
  logic             main_v_q, main_v_d;
  logic [P_W-1:0]   main_q, main_d, in_p;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             free, accept;
  assign in_p = {id_op_a_i, id_op_b_i, cu_alu_ctrl_i, id_reg_waddr_i, id_reg_we_i};
  assign {ex_op_a_o, ex_op_b_o, ex_alu_ctrl_o, ex_reg_waddr_o, ex_reg_we_o} = main_q;
  assign ex_valid_o  = main_v_q;
  assign stall_cnt_o = stall_q;
  // main slot may be overwritten this cycle: it is empty or being consumed
  assign free    = ~main_v_q | ex_ready_i;
  assign accept  = id_valid_i & id_ready_o;
  assign stall_d = (main_v_q & ~ex_ready_i & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
`ifdef ID_EX_SKID_EN
  logic           skid_v_q, skid_v_d;
  logic [P_W-1:0] skid_q, skid_d;
  assign id_ready_o = ~skid_v_q;
  // skid only fills when main is held and an input arrives; it always drains into main first
  always_comb begin
    main_v_d = flush_i ? 1'b0 : free ? (skid_v_q | accept) : main_v_q;
    main_d   = flush_i ? BUBBLE : free ? (skid_v_q ? skid_q : accept ? in_p : BUBBLE) : main_q;
    skid_v_d = ~flush_i & (skid_v_q ? ~ex_ready_i : (accept & main_v_q & ~ex_ready_i));
    skid_d   = skid_v_d ? (skid_v_q ? skid_q : in_p) : BUBBLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v_q <= 1'b0;
      skid_q   <= BUBBLE;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end
`else
  assign id_ready_o = free;
  always_comb begin
    main_v_d = flush_i ? 1'b0 : free ? accept : main_v_q;
    main_d   = flush_i ? BUBBLE : free ? (accept ? in_p : BUBBLE) : main_q;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_q   <= BUBBLE;
      stall_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
      stall_q  <= stall_d;
    end
  end
endmodule
